// File: rtl/fifo_word_packer.sv
// fifo_word_packer: read-side consumer of an async FIFO. Pops WIDTH-bit
// entries and packs RATIO of them (lane 0 = first popped) into one output
// word on a valid/ready stream. A flush pulse pushes out a partial word.
//
// state | meaning
// FILL  | issue pops and capture returning lanes until the word is full
// DRAIN | no pops; let the last read land, then emit partial word or finish
// HOLD  | word_valid_o high, word held stable until downstream accepts
module fifo_word_packer #(
  parameter int WIDTH     = 8,
  parameter int RATIO     = 4,
  parameter int CNT_WIDTH = $clog2(RATIO + 1)
) (
  input  logic                     rd_clk_i,
  input  logic                     rst_i,
  input  logic                     fifo_empty_i,
  input  logic [WIDTH-1:0]         fifo_rdata_i,
  output logic                     fifo_rd_en_o,
  input  logic                     flush_i,
  output logic [WIDTH*RATIO-1:0]   word_o,
  output logic [CNT_WIDTH-1:0]     byte_cnt_o,
  output logic                     word_valid_o,
  input  logic                     word_ready_i,
  output logic                     flush_done_o,
  output logic                     busy_o
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] RATIO_C = CNT_WIDTH'(RATIO);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [CNT_WIDTH-1:0]     r_lane_cnt;
  logic                     r_inflight;
  logic                     r_flush_pend;
  logic                     r_from_flush;
  logic [WIDTH*RATIO-1:0]   r_lanes;

  logic [CNT_WIDTH-1:0]     w_cnt_sum;
  logic                     w_rd_en;
  logic                     w_flush_done;
  logic                     w_accept;

  // Lanes already captured plus the one still on its way back from the FIFO.
  assign w_cnt_sum = r_lane_cnt + {{(CNT_WIDTH-1){1'b0}}, r_inflight};
  assign w_accept  = (r_state == ST_HOLD) && word_ready_i;

  // Next-state, pop request and flush-done pulse.
  always_comb begin
    w_next_state = r_state;
    w_rd_en      = 1'b0;
    w_flush_done = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_rd_en = !rst_i && !fifo_empty_i && !r_flush_pend && !flush_i &&
                  (w_cnt_sum < RATIO_C);
        // A word completing this edge wins over a flush; the flush is kept
        // pending and served as an empty flush after the accept.
        if (w_cnt_sum == RATIO_C) begin
          w_next_state = ST_HOLD;
        end else if (flush_i || r_flush_pend) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!r_inflight) begin
          if (r_lane_cnt != '0) begin
            w_next_state = ST_HOLD;
          end else begin
            w_next_state = ST_FILL;
            w_flush_done = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (word_ready_i) begin
          w_next_state = ST_FILL;
          w_flush_done = r_from_flush;
        end
      end
      default: w_next_state = ST_FILL;
    endcase
  end

  // State, lane capture, outstanding-read and flush bookkeeping.
  always_ff @(posedge rd_clk_i) begin
    if (rst_i) begin
      r_state      <= ST_FILL;
      r_lane_cnt   <= '0;
      r_inflight   <= 1'b0;
      r_flush_pend <= 1'b0;
      r_from_flush <= 1'b0;
      r_lanes      <= '0;
    end else begin
      r_state    <= w_next_state;
      r_inflight <= w_rd_en;

      if (w_accept) begin
        r_lanes      <= '0;
        r_lane_cnt   <= '0;
        r_from_flush <= 1'b0;
      end else begin
        if (r_inflight) begin
          for (int i = 0; i < RATIO; i++) begin
            if (r_lane_cnt == CNT_WIDTH'(i)) begin
              r_lanes[i*WIDTH +: WIDTH] <= fifo_rdata_i;
            end
          end
          r_lane_cnt <= r_lane_cnt + 1'b1;
        end
        if ((r_state == ST_DRAIN) && !r_inflight && (r_lane_cnt != '0)) begin
          r_from_flush <= 1'b1;
        end
      end

      if (r_state == ST_FILL) begin
        if (w_next_state == ST_DRAIN) begin
          r_flush_pend <= 1'b0;
        end else if (flush_i) begin
          r_flush_pend <= 1'b1;
        end
      end else if (flush_i) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  assign fifo_rd_en_o = w_rd_en;
  assign word_o       = r_lanes;
  assign byte_cnt_o   = (r_state == ST_HOLD) ? r_lane_cnt : '0;
  assign word_valid_o = (r_state == ST_HOLD);
  assign flush_done_o = w_flush_done;
  assign busy_o       = (r_lane_cnt != '0) || r_inflight || (r_state != ST_FILL);

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: a queue-based FIFO model feeds the DUT, a
// byte-stream model predicts packed words, and one compare process checks
// every accepted word, hold stability and pop legality each cycle.
module tb_fifo_word_packer;

  logic        clk;
  logic        rst;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        fifo_rd_en;
  logic        flush;
  logic [31:0] word;
  logic [2:0]  byte_cnt;
  logic        word_valid;
  logic        word_ready;
  logic        flush_done;
  logic        busy;

  fifo_word_packer #(.WIDTH(8), .RATIO(4)) dut (
    .rd_clk_i     (clk),
    .rst_i        (rst),
    .fifo_empty_i (fifo_empty),
    .fifo_rdata_i (fifo_rdata),
    .fifo_rd_en_o (fifo_rd_en),
    .flush_i      (flush),
    .word_o       (word),
    .byte_cnt_o   (byte_cnt),
    .word_valid_o (word_valid),
    .word_ready_i (word_ready),
    .flush_done_o (flush_done),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  model_bytes[$];
  logic [31:0] exp_word[$];
  logic [2:0]  exp_cnt[$];
  logic        exp_fd[$];
  logic        pop_req = 1'b0;

  logic [31:0] last_word = '0;
  int          n_words = 0;
  int          n_fd_empty = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_word = '0;
  logic [2:0]  prev_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // FIFO model: a pop sampled before the edge returns data just after it.
  always @(posedge clk) begin
    #1;
    if (pop_req && fifo_q.size() > 0) fifo_rdata = fifo_q.pop_front();
    #1;
    fifo_empty = (fifo_q.size() == 0);
  end

  always @(negedge clk) pop_req = fifo_rd_en && !rst;

  // Single compare process, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_rd_en) chk("pop_when_empty", {31'd0, fifo_empty}, 32'd0);
      if (fifo_rd_en) chk("pop_during_hold", {31'd0, word_valid}, 32'd0);
      if (prev_hold && word_valid) begin
        chk("hold_word_stable", word, prev_word);
        chk("hold_cnt_stable", {29'd0, byte_cnt}, {29'd0, prev_cnt});
      end
      if (word_valid && word_ready) begin
        if (exp_word.size() == 0) begin
          chk("unexpected_word", word, 32'hxxxx_xxxx);
        end else begin
          chk("word", word, exp_word.pop_front());
          chk("byte_cnt", {29'd0, byte_cnt}, {29'd0, exp_cnt.pop_front()});
          chk("flush_done_at_accept", {31'd0, flush_done}, {31'd0, exp_fd.pop_front()});
          last_word = word;
          n_words++;
        end
      end else if (flush_done) begin
        n_fd_empty++;
      end
      prev_hold = word_valid && !word_ready;
      prev_word = word;
      prev_cnt  = byte_cnt;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    model_bytes.push_back(b);
  endtask

  // Model: next n bytes of the stream, lane 0 first, unused lanes zero.
  task automatic expect_take(input int n, input logic fd, output logic [31:0] w);
    w = '0;
    for (int i = 0; i < n; i++) w = w | (32'(model_bytes.pop_front()) << (8 * i));
    exp_word.push_back(w);
    exp_cnt.push_back(3'(n));
    exp_fd.push_back(fd);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (exp_word.size() == 0 && !busy) break;
    end
    chk(name, {31'd0, (exp_word.size() == 0)}, 32'd1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_word"}, word, 32'd0);
    chk({tag, "_cnt"}, {29'd0, byte_cnt}, 32'd0);
    chk({tag, "_valid"}, {31'd0, word_valid}, 32'd0);
    chk({tag, "_fdone"}, {31'd0, flush_done}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_rden"}, {31'd0, fifo_rd_en}, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    int base_words, base_fd;
    rst = 1'b1; flush = 1'b0; word_ready = 1'b0;
    fifo_empty = 1'b1; fifo_rdata = '0;
    step(3);
    @(negedge clk);
    chk_zero_outputs("reset");
    step(1);
    rst = 1'b0;
    step(2);

    // Two full words back to back
    word_ready = 1'b1;
    base_words = n_words;
    for (int i = 1; i <= 8; i++) push(8'(i));
    expect_take(4, 1'b0, w);
    chk("model_word0", w, 32'h0403_0201);
    expect_take(4, 1'b0, w);
    chk("model_word1", w, 32'h0807_0605);
    wait_drain("t1_drain", 60);
    chk("t1_last_word", last_word, 32'h0807_0605);
    chk("t1_n_words", n_words - base_words, 2);
    step(3);

    // Backpressure: word held for 10 cycles
    word_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    expect_take(4, 1'b0, w);
    for (int i = 0; i < 30 && !word_valid; i++) step(1);
    chk("t2_valid_reached", {31'd0, word_valid}, 32'd1);
    repeat (10) begin
      @(negedge clk);
      chk("t2_valid_held", {31'd0, word_valid}, 32'd1);
    end
    chk("t2_busy", {31'd0, busy}, 32'd1);
    chk("t2_word_literal", word, 32'hC3C2_C1C0);
    step(1);
    word_ready = 1'b1;
    wait_drain("t2_drain", 20);
    step(3);

    // Partial word via flush
    base_fd = n_fd_empty;
    push(8'hAA); push(8'hBB);
    step(6);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    expect_take(2, 1'b1, w);
    chk("model_partial", w, 32'h0000_BBAA);
    wait_drain("t3_drain", 20);
    chk("t3_last_word", last_word, 32'h0000_BBAA);
    chk("t3_no_empty_flush", n_fd_empty - base_fd, 0);
    step(3);

    // Flush with empty packer: done one cycle later, no word
    base_words = n_words;
    base_fd = n_fd_empty;
    flush = 1'b1;
    @(negedge clk);
    chk("t4_fdone_early", {31'd0, flush_done}, 32'd0);
    step(1);
    flush = 1'b0;
    @(negedge clk);
    chk("t4_fdone_pulse", {31'd0, flush_done}, 32'd1);
    chk("t4_no_valid", {31'd0, word_valid}, 32'd0);
    step(1);
    @(negedge clk);
    chk("t4_fdone_single", {31'd0, flush_done}, 32'd0);
    step(3);
    chk("t4_fd_count", n_fd_empty - base_fd, 1);
    chk("t4_no_word", n_words - base_words, 0);

    // Flush coincident with the 4th lane capture
    base_words = n_words;
    base_fd = n_fd_empty;
    for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
    expect_take(4, 1'b0, w);
    step(4);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    wait_drain("t5_drain", 20);
    step(5);
    chk("t5_last_word", last_word, 32'h2423_2221);
    chk("t5_n_words", n_words - base_words, 1);
    chk("t5_empty_flush", n_fd_empty - base_fd, 1);
    step(3);

    // Reset with 2 lanes captured and 1 in flight
    push(8'h55); push(8'h66); push(8'h77);
    step(3);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rden_forced", {31'd0, fifo_rd_en}, 32'd0);
    step(1);
    @(negedge clk);
    chk_zero_outputs("t6_reset");
    step(1);
    rst = 1'b0;
    model_bytes.delete();
    step(2);
    for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
    expect_take(4, 1'b0, w);
    wait_drain("t6_drain", 30);
    chk("t6_clean_word", last_word, 32'h1413_1211);
    step(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
